// File: rtl/pifo_rank_queue_if.sv
// rtl/pifo_rank_queue_if.sv - push/pop/status bundle for one PIFO output port
interface pifo_rank_queue_if #(
   parameter int DEPTH           = 16,
   parameter int RANK_WIDTH      = 19,
   parameter int PIFO_INFO_WIDTH = 12,
   parameter int TAG_WIDTH       = 12,
   parameter int RESULT_WIDTH    = 32,
   parameter int DROP_CNT_WIDTH  = 16
);
   logic                       push_valid;
   logic [RESULT_WIDTH-1:0]    push_data;
   logic [TAG_WIDTH-1:0]       push_tag;
   logic                       push_ready;
   logic                       pop_req;
   logic                       pop_valid;
   logic [RANK_WIDTH-1:0]      pop_rank;
   logic [PIFO_INFO_WIDTH-1:0] pop_info;
   logic [TAG_WIDTH-1:0]       pop_tag;
   logic [RESULT_WIDTH-1:0]    last_pkt_info;
   logic [$clog2(DEPTH):0]     occupancy;
   logic                       full;
   logic                       empty;
   logic [DROP_CNT_WIDTH-1:0]  drop_count;

   modport master (
      output push_valid, push_data, push_tag, pop_req,
      input  push_ready, pop_valid, pop_rank, pop_info, pop_tag,
             last_pkt_info, occupancy, full, empty, drop_count
   );

   modport slave (
      input  push_valid, push_data, push_tag, pop_req,
      output push_ready, pop_valid, pop_rank, pop_info, pop_tag,
             last_pkt_info, occupancy, full, empty, drop_count
   );
endinterface

// File: rtl/pifo_rank_queue.sv
// rtl/pifo_rank_queue.sv - sorted shift-register PIFO keyed on {round, class}
module pifo_rank_queue #(
   parameter int DEPTH           = 16,
   parameter int RANK_WIDTH      = 19,
   parameter int CLASS_WIDTH     = 5,
   parameter int ROUND_WIDTH     = 11,
   parameter int PIFO_INFO_WIDTH = 12,
   parameter int TAG_WIDTH       = 12,
   parameter int RESULT_WIDTH    = 32,
   parameter int DROP_CNT_WIDTH  = 16
) (
   input logic              clk_dp,
   input logic              rst,
   pifo_rank_queue_if.slave q
);
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam int KEY_W = ROUND_WIDTH + CLASS_WIDTH;
   localparam int PAD_W = RESULT_WIDTH - KEY_W - PIFO_INFO_WIDTH;

   typedef struct packed {
      logic                       vld;
      logic [RANK_WIDTH-1:0]      rank;
      logic [PIFO_INFO_WIDTH-1:0] info;
      logic [TAG_WIDTH-1:0]       tag;
   } slot_t;

   slot_t            slot     [DEPTH];
   slot_t            shifted  [DEPTH];
   slot_t            slot_nxt [DEPTH];
   slot_t            new_ent;
   logic [KEY_W-1:0] new_key;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_nxt;
   logic [OCC_W-1:0] ins_cnt;
   logic [OCC_W-1:0] ins_pos;
   logic             full_r;
   logic             empty_r;
   logic             do_pop;
   logic             push_acc;
   logic             unused_valid_flag;

   // Round is the major sort field, class breaks ties within a round.
   function automatic logic [KEY_W-1:0] key_of(input logic [RANK_WIDTH-1:0] r);
      return {r[ROUND_WIDTH-1:0], r[KEY_W-1:ROUND_WIDTH]};
   endfunction

   // The tuple's own valid flag carries no meaning here; push_valid qualifies it.
   assign unused_valid_flag = q.push_data[RESULT_WIDTH-1];

   assign new_ent  = {1'b1, q.push_data[RESULT_WIDTH-2 -: RANK_WIDTH],
                      q.push_data[PIFO_INFO_WIDTH-1:0], q.push_tag};
   assign new_key  = key_of(new_ent.rank);
   assign do_pop   = q.pop_req && !empty_r;
   assign push_acc = q.push_valid && (!full_r || q.pop_req);

   assign q.push_ready = !full_r | q.pop_req;
   assign q.occupancy  = occ;
   assign q.full       = full_r;
   assign q.empty      = empty_r;

   // Count entries that sort at or before the new one; equal keys stay ahead (FIFO tie-break).
   always_comb begin
      ins_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot[i].vld && (key_of(slot[i].rank) <= new_key))
            ins_cnt = ins_cnt + OCC_W'(1);
      end
      if (do_pop)
         ins_pos = (ins_cnt == '0) ? '0 : ins_cnt - OCC_W'(1);
      else
         ins_pos = ins_cnt;
   end

   // Down-shift for a departing head, then open a hole at ins_pos for an accepted push.
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++)
         shifted[i] = do_pop ? slot[i+1] : slot[i];
      shifted[DEPTH-1] = do_pop ? '0 : slot[DEPTH-1];

      for (int i = 0; i < DEPTH; i++)
         slot_nxt[i] = shifted[i];
      if (push_acc) begin
         if (ins_pos == '0)
            slot_nxt[0] = new_ent;
         for (int i = 1; i < DEPTH; i++) begin
            if (OCC_W'(i) > ins_pos)
               slot_nxt[i] = shifted[i-1];
            else if (OCC_W'(i) == ins_pos)
               slot_nxt[i] = new_ent;
         end
      end
   end

   // Entry count after this cycle's push/pop.
   always_comb begin
      occ_nxt = occ;
      case ({push_acc, do_pop})
         2'b10:   occ_nxt = occ + OCC_W'(1);
         2'b01:   occ_nxt = occ - OCC_W'(1);
         default: occ_nxt = occ;
      endcase
   end

   // Queue storage, status flags, registered pop outputs and drop counter.
   always_ff @(posedge clk_dp or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            slot[i] <= '0;
         occ             <= '0;
         full_r          <= 1'b0;
         empty_r         <= 1'b1;
         q.pop_valid     <= 1'b0;
         q.pop_rank      <= '0;
         q.pop_info      <= '0;
         q.pop_tag       <= '0;
         q.last_pkt_info <= '0;
         q.drop_count    <= '0;
      end else begin
         slot        <= slot_nxt;
         occ         <= occ_nxt;
         full_r      <= (occ_nxt == OCC_W'(DEPTH));
         empty_r     <= (occ_nxt == '0);
         q.pop_valid <= do_pop;
         if (do_pop) begin
            q.pop_rank      <= slot[0].rank;
            q.pop_info      <= slot[0].info;
            q.pop_tag       <= slot[0].tag;
            q.last_pkt_info <= {{PAD_W{1'b0}}, slot[0].rank[ROUND_WIDTH-1:0],
                                slot[0].rank[KEY_W-1:ROUND_WIDTH], slot[0].info};
         end
         if (q.push_valid && !push_acc && (q.drop_count != '1))
            q.drop_count <= q.drop_count + 1'b1;
      end
   end
endmodule
